servo_group_commander: RTL and testbench

- Parametrised successor to the single-servo command sender. Builds one group-move ASCII frame for up to NUM_SERVOS channels, e.g. "#001P1500#003P2000T1000!".
- Converts each channel's binary pulse width, and the shared move time, to 4 decimal digits internally.
- Streams the frame byte by byte over a valid/ready byte interface to the UART transmitter.
- Sits between the vision/control logic and the UART TX.

---
 rtl/servo_pkg.sv | 35 +++
 rtl/servo_group_commander_if.sv | 11 +
 rtl/bin_to_bcd4.sv | 55 +++++
 rtl/servo_group_commander.sv | 239 +++++++++++++++++++++++
 tb/tb_servo_group_commander.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/servo_pkg.sv
// Shared ASCII constants, move-time limit and FSM state encoding for the
// servo group-move frame builder.
package servo_pkg;

    localparam logic [7:0] CH_HASH = 8'h23;
    localparam logic [7:0] CH_P    = 8'h50;
    localparam logic [7:0] CH_T    = 8'h54;
    localparam logic [7:0] CH_BANG = 8'h21;
    localparam logic [7:0] CH_ZERO = 8'h30;

    localparam int unsigned TIME_MAX = 9999;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        CONV_P,
        HDR,
        DIG,
        CONV_T,
        TRL,
        DONE
    } state_t;

    // Only ever called with elaboration-time constants, so the divides fold away.
    function automatic logic [23:0] id_ascii(input int unsigned id);
        return {8'(CH_ZERO + (id / 100) % 10),
                8'(CH_ZERO + (id / 10) % 10),
                8'(CH_ZERO + id % 10)};
    endfunction

    function automatic logic [7:0] bcd_ascii(input logic [3:0] d);
        return CH_ZERO + {4'd0, d};
    endfunction

endpackage

// File: rtl/servo_group_commander_if.sv
// Byte stream from the frame builder to the UART transmitter.
interface servo_group_commander_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/bin_to_bcd4.sv
// Iterative 14-bit binary to 4-digit BCD converter (shift-add-3); done pulses
// 15 cycles after start.
module bin_to_bcd4 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] bin,
    output logic [15:0] bcd,
    output logic        done
);

    logic [13:0] sh_q, sh_d;
    logic [15:0] bcd_q, bcd_d;
    logic [15:0] adj;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        sh_d   = sh_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start) begin
            sh_d  = bin;
            bcd_d = '0;
            cnt_d = 4'd14;
        end else if (cnt_q != 4'd0) begin
            {bcd_d, sh_d} = {adj, sh_q} << 1;
            cnt_d  = cnt_q - 4'd1;
            done_d = (cnt_q == 4'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bcd  = bcd_q;
    assign done = done_q;

endmodule

// File: rtl/servo_group_commander.sv
// Builds "#iiiPpppp...Tmmmm!" group-move frames and streams them byte by byte.
//   state  | meaning
//   IDLE   | wait for go rising edge, snapshot inputs
//   SCAN   | pick lowest pending channel, clamp pulse, start conversion
//   CONV_P | wait for pulse BCD
//   HDR    | send '#', 3 ID digits, 'P'
//   DIG    | send 4 pulse digits
//   CONV_T | wait for move-time BCD
//   TRL    | send 'T', 4 time digits, '!'
//   DONE   | one-cycle done pulse
module servo_group_commander
    import servo_pkg::*;
#(
    parameter int NUM_SERVOS = 4,
    parameter int ID_BASE    = 1,
    parameter int PW_W       = 12,
    parameter int PW_MIN     = 500,
    parameter int PW_MAX     = 2500,
    parameter int TIME_W     = 14
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       go,
    input  logic [NUM_SERVOS-1:0]      ch_enable,
    input  logic [NUM_SERVOS*PW_W-1:0] pulse_us,
    input  logic [TIME_W-1:0]          move_ms,
    servo_group_commander_if.master    tx,
    output logic                       busy,
    output logic                       done,
    output logic                       clamp_flag,
    output logic                       empty_err
);

    localparam int IDX_W = (NUM_SERVOS > 1) ? $clog2(NUM_SERVOS) : 1;

    state_t                     state_q, state_d;
    logic                       go_q;
    logic [NUM_SERVOS-1:0]      rem_q, rem_d;
    logic [NUM_SERVOS*PW_W-1:0] pw_q, pw_d;
    logic [TIME_W-1:0]          ms_q, ms_d;
    logic [IDX_W-1:0]           idx_q, idx_d, low_idx;
    logic [3:0]                 cnt_q, cnt_d;
    logic [7:0]                 data_q, data_d;
    logic valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic clamp_q, clamp_d, empty_q, empty_d;

    logic [PW_W-1:0] pw_sel;
    logic [13:0]     pw_clamped, ms_clamped, conv_bin;
    logic            pw_clip, ms_clip, conv_start, bcd_done, xfer;
    logic [15:0]     bcd;
    logic [23:0]     id_lut [NUM_SERVOS];

    for (genvar g = 0; g < NUM_SERVOS; g++) begin : g_id
        assign id_lut[g] = id_ascii(ID_BASE + g);
    end

    function automatic logic [7:0] ch_byte(input logic [3:0] k, input logic [23:0] id,
                                           input logic [15:0] d);
        case (k)
            4'd0:    ch_byte = CH_HASH;
            4'd1:    ch_byte = id[23:16];
            4'd2:    ch_byte = id[15:8];
            4'd3:    ch_byte = id[7:0];
            4'd4:    ch_byte = CH_P;
            4'd5:    ch_byte = bcd_ascii(d[15:12]);
            4'd6:    ch_byte = bcd_ascii(d[11:8]);
            4'd7:    ch_byte = bcd_ascii(d[7:4]);
            default: ch_byte = bcd_ascii(d[3:0]);
        endcase
    endfunction

    function automatic logic [7:0] trl_byte(input logic [3:0] k, input logic [15:0] d);
        case (k)
            4'd0:    trl_byte = CH_T;
            4'd1:    trl_byte = bcd_ascii(d[15:12]);
            4'd2:    trl_byte = bcd_ascii(d[11:8]);
            4'd3:    trl_byte = bcd_ascii(d[7:4]);
            4'd4:    trl_byte = bcd_ascii(d[3:0]);
            default: trl_byte = CH_BANG;
        endcase
    endfunction

    always_comb begin
        low_idx = '0;
        for (int i = NUM_SERVOS - 1; i >= 0; i--) begin
            if (rem_q[i]) low_idx = IDX_W'(i);
        end
    end

    assign pw_sel = pw_q[low_idx*PW_W +: PW_W];

    always_comb begin
        pw_clip = 1'b1;
        if (32'(pw_sel) < PW_MIN)      pw_clamped = 14'(PW_MIN);
        else if (32'(pw_sel) > PW_MAX) pw_clamped = 14'(PW_MAX);
        else begin
            pw_clamped = 14'(pw_sel);
            pw_clip    = 1'b0;
        end
        ms_clip    = 32'(ms_q) > TIME_MAX;
        ms_clamped = ms_clip ? 14'(TIME_MAX) : 14'(ms_q);
    end

    assign xfer = valid_q & tx.tx_ready;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        pw_d       = pw_q;
        ms_d       = ms_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        clamp_d    = clamp_q;
        empty_d    = empty_q;
        conv_start = 1'b0;
        conv_bin   = pw_clamped;
        unique case (state_q)
            IDLE: if (go && !go_q) begin
                rem_d   = ch_enable;
                pw_d    = pulse_us;
                ms_d    = move_ms;
                clamp_d = 1'b0;
                empty_d = 1'b0;
                if (ch_enable == '0) begin
                    done_d  = 1'b1;
                    empty_d = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                idx_d      = low_idx;
                rem_d      = rem_q & ~(NUM_SERVOS'(1) << low_idx);
                conv_start = 1'b1;
                clamp_d    = clamp_q | pw_clip;
                state_d    = CONV_P;
            end
            CONV_P: if (bcd_done) begin
                valid_d = 1'b1;
                cnt_d   = 4'd0;
                data_d  = CH_HASH;
                state_d = HDR;
            end
            HDR: if (xfer) begin
                cnt_d  = cnt_q + 4'd1;
                data_d = ch_byte(cnt_q + 4'd1, id_lut[idx_q], bcd);
                if (cnt_q == 4'd4) state_d = DIG;
            end
            DIG: if (xfer) begin
                if (cnt_q == 4'd8) begin
                    valid_d = 1'b0;
                    if (|rem_q) state_d = SCAN;
                    else begin
                        state_d    = CONV_T;
                        conv_start = 1'b1;
                        conv_bin   = ms_clamped;
                        clamp_d    = clamp_q | ms_clip;
                    end
                end else begin
                    cnt_d  = cnt_q + 4'd1;
                    data_d = ch_byte(cnt_q + 4'd1, id_lut[idx_q], bcd);
                end
            end
            CONV_T: if (bcd_done) begin
                valid_d = 1'b1;
                cnt_d   = 4'd0;
                data_d  = CH_T;
                state_d = TRL;
            end
            TRL: if (xfer) begin
                if (cnt_q == 4'd5) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d  = cnt_q + 4'd1;
                    data_d = trl_byte(cnt_q + 4'd1, bcd);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            go_q    <= 1'b0;
            rem_q   <= '0;
            pw_q    <= '0;
            ms_q    <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clamp_q <= 1'b0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            go_q    <= go;
            rem_q   <= rem_d;
            pw_q    <= pw_d;
            ms_q    <= ms_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            clamp_q <= clamp_d;
            empty_q <= empty_d;
        end
    end

    bin_to_bcd4 u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (conv_bin),
        .bcd   (bcd),
        .done  (bcd_done)
    );

    assign tx.tx_data  = data_q;
    assign tx.tx_valid = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign clamp_flag  = clamp_q;
    assign empty_err   = empty_q;

endmodule

// File: tb/tb_servo_group_commander.sv
// Directed bench: a string-level frame model checked byte by byte on every
// transfer, plus literal frame strings and timing points.
module tb_servo_group_commander;

    localparam int N      = 4;
    localparam int PW_W   = 12;
    localparam int TIME_W = 14;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 go  = 1'b0;
    logic [N-1:0]         ch_enable = '0;
    logic [N*PW_W-1:0]    pulse_us  = '0;
    logic [TIME_W-1:0]    move_ms   = '0;
    logic                 busy, done, clamp_flag, empty_err;

    servo_group_commander_if tx_if();

    servo_group_commander #(
        .NUM_SERVOS(N), .ID_BASE(1), .PW_W(PW_W),
        .PW_MIN(500), .PW_MAX(2500), .TIME_W(TIME_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .ch_enable  (ch_enable),
        .pulse_us   (pulse_us),
        .move_ms    (move_ms),
        .tx         (tx_if),
        .busy       (busy),
        .done       (done),
        .clamp_flag (clamp_flag),
        .empty_err  (empty_err)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic       exp_clamp = 1'b0;
    logic       exp_empty = 1'b0;
    string      rx_str = "";
    int         xfer_cnt = 0;
    int         done_cnt = 0;
    int         rdy_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic check_str(input string name, input string act, input string req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, req);
        end
    endtask

    function automatic logic [N*PW_W-1:0] pack4(input int a, input int b, input int c, input int d);
        return {12'(d), 12'(c), 12'(b), 12'(a)};
    endfunction

    // Frame as text: per enabled channel "#" id "P" pulse, then "T" time "!".
    function automatic string model_frame(input logic [N-1:0] en, input logic [N*PW_W-1:0] pw,
                                          input int ms, output logic clip);
        string s;
        int    v;
        s    = "";
        clip = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (en[i]) begin
                v = int'(pw[i*PW_W +: PW_W]);
                if (v < 500) begin v = 500; clip = 1'b1; end
                else if (v > 2500) begin v = 2500; clip = 1'b1; end
                s = {s, $sformatf("#%03dP%04d", 1 + i, v)};
            end
        end
        if (ms > 9999) begin ms = 9999; clip = 1'b1; end
        s = {s, $sformatf("T%04d!", ms)};
        return s;
    endfunction

    task automatic start_req(input logic [N-1:0] en, input logic [N*PW_W-1:0] pw, input int ms);
        string s;
        logic  c;
        ch_enable = en;
        pulse_us  = pw;
        move_ms   = TIME_W'(ms);
        exp_q.delete();
        rx_str   = "";
        xfer_cnt = 0;
        if (en == '0) begin
            exp_empty = 1'b1;
            exp_clamp = 1'b0;
        end else begin
            s = model_frame(en, pw, ms, c);
            exp_clamp = c;
            exp_empty = 1'b0;
            for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        end
        go = 1'b1;
    endtask

    task automatic wait_done(input int d0);
        for (int n = 0; n < 3000 && done_cnt == d0; n++) @(posedge clk);
    endtask

    task automatic run_frame(input logic [N-1:0] en, input logic [N*PW_W-1:0] pw, input int ms,
                             input string lit, input string tag);
        int d0;
        @(posedge clk); #2;
        d0 = done_cnt;
        start_req(en, pw, ms);
        repeat (3) @(posedge clk);
        #2 go = 1'b0;
        wait_done(d0);
        repeat (30) @(posedge clk);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check_str({tag, "_frame"}, rx_str, lit);
        check({tag, "_len"}, xfer_cnt, lit.len());
    endtask

    // tx_ready: tied high, or repeating 1-0-0-1.
    initial begin
        int k;
        k = 0;
        tx_if.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            k++;
            tx_if.tx_ready = (rdy_mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
        end
    end

    // Per-cycle compare against the model.
    initial begin
        bit         stall_q;
        logic [7:0] stall_data;
        stall_q    = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_q = 1'b0;
            end else begin
                if (stall_q) begin
                    check("stall_valid", tx_if.tx_valid, 1);
                    check("stall_data", tx_if.tx_data, stall_data);
                end
                if (tx_if.tx_valid) check("valid_needs_busy", busy, 1);
                if (tx_if.tx_valid && tx_if.tx_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_byte: got 0x%0h with no byte expected", tx_if.tx_data);
                    end else begin
                        check("byte", tx_if.tx_data, exp_q.pop_front());
                    end
                    rx_str = $sformatf("%s%c", rx_str, tx_if.tx_data);
                    xfer_cnt++;
                end
                stall_q    = tx_if.tx_valid && !tx_if.tx_ready;
                stall_data = tx_if.tx_data;
                if (done) begin
                    done_cnt++;
                    check("done_busy_low", busy, 0);
                    check("done_clamp", clamp_flag, exp_clamp);
                    check("done_empty", empty_err, exp_empty);
                    check("done_bytes_left", exp_q.size(), 0);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_tx_data", tx_if.tx_data, 0);
        check("rst_tx_valid", tx_if.tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_clamp", clamp_flag, 0);
        check("rst_empty", empty_err, 0);
        rst = 1'b0;

        run_frame(4'b1111, pack4(1500, 1500, 2000, 500), 1000,
                  "#001P1500#002P1500#003P2000#004P0500T1000!", "t1");
        check("t1_clamp", clamp_flag, 0);

        rdy_mode = 1;
        run_frame(4'b0101, pack4(1500, 4000, 600, 0), 250, "#001P1500#003P0600T0250!", "t2");
        rdy_mode = 0;

        run_frame(4'b0011, pack4(3000, 100, 1500, 1500), 12000, "#001P2500#002P0500T9999!", "t3");
        check("t3_clamp", clamp_flag, 1);

        // Empty request: done and empty_err exactly one cycle after the go edge.
        @(posedge clk); #2;
        start_req('0, pack4(1500, 1500, 1500, 1500), 100);
        @(negedge clk);
        check("t4_done_early", done, 0);
        @(negedge clk);
        check("t4_done", done, 1);
        check("t4_empty", empty_err, 1);
        check("t4_busy", busy, 0);
        @(negedge clk);
        check("t4_done_once", done, 0);
        check("t4_busy_after", busy, 0);
        go = 1'b0;
        repeat (20) @(posedge clk);
        check("t4_no_bytes", xfer_cnt, 0);

        // Mid-frame input changes and extra go edges must not disturb the frame.
        @(posedge clk); #2;
        d0 = done_cnt;
        start_req(4'b1111, pack4(1234, 800, 2222, 1999), 50);
        repeat (2) @(posedge clk);
        #2 go = 1'b0;
        repeat (25) @(posedge clk);
        #2;
        check("t5_busy_mid", busy, 1);
        pulse_us  = pack4(700, 700, 700, 700);
        ch_enable = 4'b0001;
        move_ms   = 14'd9000;
        go        = 1'b1;
        repeat (2) @(posedge clk);
        #2 go = 1'b0;
        repeat (40) @(posedge clk);
        #2 go = 1'b1;
        wait_done(d0);
        repeat (5) @(posedge clk);
        #2 go = 1'b0;
        repeat (100) @(posedge clk);
        check("t5_done_pulses", done_cnt - d0, 1);
        check_str("t5_frame", rx_str, "#001P1234#002P0800#003P2222#004P1999T0050!");

        // Asynchronous reset after 7 bytes, then a fresh frame.
        @(posedge clk); #2;
        start_req(4'b1111, pack4(1500, 1600, 1700, 1800), 3000);
        repeat (2) @(posedge clk);
        #2 go = 1'b0;
        for (int n = 0; n < 500 && xfer_cnt < 7; n++) @(posedge clk);
        check("t6_seven_bytes", xfer_cnt, 7);
        #2;
        check("t6_valid_before", tx_if.tx_valid, 1);
        check("t6_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("t6_valid_async", tx_if.tx_valid, 0);
        check("t6_busy_async", busy, 0);
        check("t6_done_async", done, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (40) @(posedge clk);
        check("t6_no_recovery", xfer_cnt, 7);
        run_frame(4'b1111, pack4(900, 2100, 1500, 2500), 4321,
                  "#001P0900#002P2100#003P1500#004P2500T4321!", "t6_fresh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
